// File: rtl/sign_narrow_packer_pkg.sv
// Shared constants and width helpers for the sign-narrowing store packer.
package sign_narrow_packer_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned OUT_W_DEF = 4;
    localparam int unsigned LANES_DEF = 2;

    function automatic int lane_max(input int unsigned out_w);
        return (2 ** (out_w - 1)) - 1;
    endfunction

    function automatic int lane_min(input int unsigned out_w);
        return -(2 ** (out_w - 1));
    endfunction

    localparam int LANE_MAX = lane_max(OUT_W_DEF);
    localparam int LANE_MIN = lane_min(OUT_W_DEF);

    // A single-lane build still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/sign_narrow_lane.sv
// Combinational narrowing of one signed value to a lane with an overflow flag.
// NARROW_SAT_EN selects clamping of out-of-range values; otherwise they wrap.
module sign_narrow_lane
    import sign_narrow_packer_pkg::*;
#(
    parameter int unsigned IN_W    = WORD_W,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int          LaneMax = LANE_MAX,
    parameter int          LaneMin = LANE_MIN
) (
    input  logic [IN_W-1:0]  in_data_i,
    output logic [OUT_W-1:0] lane_o,
    output logic             sat_o
);

    localparam logic signed [IN_W-1:0] MaxIn = IN_W'(LaneMax);
    localparam logic signed [IN_W-1:0] MinIn = IN_W'(LaneMin);

`ifdef NARROW_SAT_EN
    localparam logic [OUT_W-1:0] MaxLane = OUT_W'(LaneMax);
    localparam logic [OUT_W-1:0] MinLane = OUT_W'(LaneMin);
`endif

    logic over;
    logic under;

    always_comb begin
        over  = $signed(in_data_i) > MaxIn;
        under = $signed(in_data_i) < MinIn;
        sat_o = over | under;
`ifdef NARROW_SAT_EN
        if (over) begin
            lane_o = MaxLane;
        end else if (under) begin
            lane_o = MinLane;
        end else begin
            lane_o = in_data_i[OUT_W-1:0];
        end
`else
        lane_o = in_data_i[OUT_W-1:0];
`endif
    end

endmodule

// File: rtl/sign_narrow_packer.sv
// Narrows signed datapath values and packs LANES lanes per memory write word.
// Out-of-range handling is chosen by NARROW_SAT_EN inside sign_narrow_lane.
module sign_narrow_packer
    import sign_narrow_packer_pkg::*;
#(
    parameter int unsigned IN_W  = WORD_W,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned LANES = LANES_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W*LANES-1:0]       out_data,
    output logic [$clog2(LANES+1)-1:0]   out_count,
    output logic [LANES-1:0]             out_sat
);

    localparam int unsigned IdxW  = idx_width(LANES);
    localparam int unsigned CntW  = cnt_width(LANES);
    localparam int unsigned WordW = OUT_W * LANES;

    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WordW-1:0] acc_q, acc_d;
    logic [LANES-1:0] sat_acc_q, sat_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [WordW-1:0] out_data_q, out_data_d;
    logic [CntW-1:0]  out_count_q, out_count_d;
    logic [LANES-1:0] out_sat_q, out_sat_d;

    logic [OUT_W-1:0] lane;
    logic             lane_sat;
    logic             accept;
    logic             complete;
    logic [WordW-1:0] acc_ins;
    logic [LANES-1:0] sat_ins;

    sign_narrow_lane #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .LaneMax (lane_max(OUT_W)),
        .LaneMin (lane_min(OUT_W))
    ) u_lane (
        .in_data_i (in_data),
        .lane_o    (lane),
        .sat_o     (lane_sat)
    );

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        complete = accept && (in_last || (idx_q == IdxW'(LANES - 1)));

        // Accumulator plus the lane arriving this cycle.
        acc_ins = acc_q;
        sat_ins = sat_acc_q;
        for (int l = 0; l < LANES; l++) begin
            if (idx_q == IdxW'(l)) begin
                acc_ins[l*OUT_W +: OUT_W] = lane;
                sat_ins[l]                = lane_sat;
            end
        end

        idx_d       = idx_q;
        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        if (complete) begin
            // A completing beat may coincide with the previous word's handshake.
            out_valid_d = 1'b1;
            out_data_d  = acc_ins;
            out_sat_d   = sat_ins;
            out_count_d = CntW'(idx_q) + CntW'(1);
            idx_d       = '0;
            acc_d       = '0;
            sat_acc_d   = '0;
        end else begin
            if (accept) begin
                idx_d     = idx_q + IdxW'(1);
                acc_d     = acc_ins;
                sat_acc_d = sat_ins;
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            acc_q       <= '0;
            sat_acc_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= '0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_sign_narrow_packer.sv
// Scoreboard bench for sign_narrow_packer; honours NARROW_SAT_EN in its model.
module tb_sign_narrow_packer;

    typedef struct {
        logic [7:0] data;
        logic [1:0] cnt;
        logic [1:0] sat;
    } word_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_count;
    logic [1:0] out_sat;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    rr_en = 1'b0;
    bit    ready_force = 1'b1;

    word_t sb_q[$];
    int    lat_q[$];
    int    part_lane[$];
    int    part_sat[$];

    sign_narrow_packer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference narrowing from the value's numeric range.
    task automatic narrow(input logic [7:0] d, output int lane, output int sat);
        int v;
        v = $signed(d);
        sat = (v > 7 || v < -8) ? 1 : 0;
`ifdef NARROW_SAT_EN
        if (v > 7) lane = 7;
        else if (v < -8) lane = 8;
        else lane = ((v % 16) + 16) % 16;
`else
        lane = ((v % 16) + 16) % 16;
`endif
    endtask

    // Input-side model: observes accepted beats, predicts words.
    always @(negedge clk) begin
        int    ln;
        int    st;
        int    w;
        int    s;
        word_t wd;
        if (reset) begin
            part_lane.delete();
            part_sat.delete();
            sb_q.delete();
            lat_q.delete();
        end else if (in_valid && in_ready) begin
            narrow(in_data, ln, st);
            part_lane.push_back(ln);
            part_sat.push_back(st);
            if (in_last || part_lane.size() == 2) begin
                w = 0;
                s = 0;
                for (int i = 0; i < part_lane.size(); i++) begin
                    w += part_lane[i] * (16 ** i);
                    s += part_sat[i] * (2 ** i);
                end
                wd.data = 8'(w);
                wd.sat  = 2'(s);
                wd.cnt  = 2'(part_lane.size());
                sb_q.push_back(wd);
                lat_q.push_back(cyc + 1);
                part_lane.delete();
                part_sat.delete();
            end
        end
    end

    // Output-side monitor.
    always @(negedge clk) begin
        word_t e;
        if (!reset) begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (lat_q.size() > 0 && lat_q[0] == cyc) begin
                chk("latency_valid", 32'(out_valid), 32'd1);
                void'(lat_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("word_data", 32'(out_data), 32'(e.data));
                    chk("word_count", 32'(out_count), 32'(e.cnt));
                    chk("word_sat", 32'(out_sat), 32'(e.sat));
                end
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rr_en ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no in_ready expected accept of %0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bnd [8];
        bnd = '{8'h07, 8'hF8, 8'h08, 8'hF7, 8'h80, 8'h7F, 8'h00, 8'hFF};

        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        chk("reset_count", 32'(out_count), 32'd0);
        chk("reset_sat", 32'(out_sat), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed words.
        idle(1);
        send(8'h05, 1'b0);
        send(8'hFD, 1'b0);
        @(negedge clk);
        chk("d5_valid", 32'(out_valid), 32'd1);
        chk("d5_data", 32'(out_data), 32'hD5);
        @(negedge clk);
        chk("d5_drop", 32'(out_valid), 32'd0);
        idle(1);
        send(8'h40, 1'b0);
        send(8'h80, 1'b0);
        send(8'h03, 1'b1);
        send(8'h07, 1'b0);
        send(8'hF8, 1'b0);
        send(8'h08, 1'b0);
        send(8'hF7, 1'b0);
        idle(4);

        // Back-pressure: hold a word, offer a new beat, release without bubble.
        ready_force = 1'b0;
        idle(2);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
            if (sb_q.size() > 0) begin
                chk("hold_data", 32'(out_data), 32'(sb_q[0].data));
                chk("hold_count", 32'(out_count), 32'(sb_q[0].cnt));
            end
            if (i == 2) ready_force = 1'b1;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        chk("no_bubble_valid", 32'(out_valid), 32'd1);
        chk("no_bubble_data", 32'(out_data), 32'h03);
        idle(4);

        // Reset in the middle of a word.
        send(8'h05, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_valid", 32'(out_valid), 32'd0);
        chk("midreset_data", 32'(out_data), 32'd0);
        chk("midreset_count", 32'(out_count), 32'd0);
        chk("midreset_sat", 32'(out_sat), 32'd0);
        idle(1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        @(negedge clk);
        chk("after_reset_data", 32'(out_data), 32'h21);
        idle(3);

        // Randomized traffic with random back-pressure.
        rr_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [7:0] d;
            if ($urandom_range(0, 1) == 0) d = 8'($urandom_range(0, 255));
            else d = bnd[$urandom_range(0, 7)];
            send(d, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rr_en = 1'b0;
        ready_force = 1'b1;
        for (int n = 0; n < 50 && (sb_q.size() != 0 || part_lane.size() != 0); n++) begin
            if (part_lane.size() != 0) send(8'h00, 1'b1);
            else idle(1);
        end
        idle(3);
        chk("drain_queue", 32'(sb_q.size()), 32'd0);
        chk("drain_latency", 32'(lat_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
